// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle MIPS datapath and mem_responder.
// The initiator drives the request side; the responder drives the completion side.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (output req, wr, Address, WriteData,
                  input  ReadData, ack, busy, err);
  modport slave  (input  req, wr, Address, WriteData,
                  output ReadData, ack, busy, err);
endinterface

// File: rtl/mem_responder.sv
// Word RAM responder with fixed read latency READ_LAT and single-cycle writes.
// Optional MEM_ALIGN_CHECK_EN flags misaligned byte addresses and suppresses their effect.
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic           Clk,
  input  logic           Reset_signal_n,
  mem_responder_if.slave bus
);

  if (READ_LAT < 1 || READ_LAT > 15) begin : g_lat_chk
    $error("mem_responder: READ_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE, RESP} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              ack_q, busy_q, err_q, mis_q;
  logic [31:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0] acc_idx;
  logic              acc_mis;
  logic              mem_we;
  logic              unused_addr;

  assign acc_idx     = bus.Address[ADDR_W+1:2];
  assign unused_addr = ^{bus.Address[31:ADDR_W+2], bus.Address[1:0]};
`ifdef MEM_ALIGN_CHECK_EN
  assign acc_mis = |bus.Address[1:0];
`else
  assign acc_mis = 1'b0;
`endif

  // RAM has no reset; a reset before the WRITE edge leaves state_q != WRITE, so nothing commits.
  assign mem_we = (state_q == WRITE) && !mis_q;

  always_ff @(posedge Clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge Clk or negedge Reset_signal_n) begin
    if (!Reset_signal_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            idx_q   <= acc_idx;
            wdata_q <= bus.WriteData;
            mis_q   <= acc_mis;
            busy_q  <= 1'b1;
            if (bus.wr) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ_WAIT;
              cnt_q   <= 4'(READ_LAT - 1);
            end
          end
        end
        WRITE: begin
          ack_q   <= 1'b1;
          err_q   <= mis_q;
          state_q <= RESP;
        end
        READ_WAIT: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= mis_q ? 32'h0 : mem[idx_q];
            ack_q   <= 1'b1;
            err_q   <= mis_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a driver pushes expected completions computed
// from a word-array model; an independent monitor pops them on every ack.
module tb_mem_responder;
  localparam int ADDR_W   = 8;
  localparam int READ_LAT = 2;
  localparam int DEPTH    = 2**ADDR_W;

  logic Clk = 1'b0;
  logic Reset_signal_n = 1'b1;

  mem_responder_if bus();

  mem_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .Clk(Clk), .Reset_signal_n(Reset_signal_n), .bus(bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [DEPTH];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Reset_signal_n) begin
      if (bus.ack) begin
        if (q.size() == 0) flag("unexpected_ack");
        else begin
          exp_t e;
          e = q.pop_front();
          check("ack_cycle", cyc, e.cyc);
          check("ack_err", {31'b0, bus.err}, {31'b0, e.err});
          if (e.is_rd) check("rdata", bus.ReadData, e.data);
        end
      end else begin
        check("err_without_ack", {31'b0, bus.err}, 32'h0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Clk);
    while (bus.busy && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) flag("idle_timeout");
  endtask

  // Issue one request from a negedge where the DUT is idle; returns at the negedge after accept.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic track);
    exp_t e;
    int   idx;
    logic mis;
    wait_idle();
    idx = int'(a[ADDR_W+1:2]);
`ifdef MEM_ALIGN_CHECK_EN
    mis = |a[1:0];
`else
    mis = 1'b0;
`endif
    e.is_rd = !w;
    e.err   = mis;
    e.cyc   = cyc + 1 + (w ? 1 : READ_LAT);
    e.data  = mis ? 32'h0 : model[idx];
    if (track) begin
      if (w && !mis) model[idx] = d;
      q.push_back(e);
    end
    bus.req = 1'b1; bus.wr = w; bus.Address = a; bus.WriteData = d;
    @(negedge Clk);
    bus.req = 1'b0;
    check("busy_after_accept", {31'b0, bus.busy}, 32'h1);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    bus.req = 1'b0; bus.wr = 1'b0; bus.Address = '0; bus.WriteData = '0;

    #1 Reset_signal_n = 1'b0;
    #1;
    check("rst_rdata", bus.ReadData, 32'h0);
    check("rst_ack",   {31'b0, bus.ack},  32'h0);
    check("rst_busy",  {31'b0, bus.busy}, 32'h0);
    check("rst_err",   {31'b0, bus.err},  32'h0);
    repeat (2) @(negedge Clk);
    Reset_signal_n = 1'b1;

    // Fill every word so later reads never hit uninitialised RAM.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b1);

    // Write then read.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);

    // Request while busy is dropped, not queued.
    issue(1'b0, 32'h44, 32'h0, 1'b1);
    bus.req = 1'b1; bus.wr = 1'b1; bus.Address = 32'h10; bus.WriteData = 32'h0;
    @(negedge Clk);
    bus.req = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 1'b1);

    // Upper address bits wrap.
    issue(1'b1, 32'h400, 32'h12345678, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 1'b1);

    // Misaligned accesses (err/suppression only with the check enabled).
    issue(1'b1, 32'h22, 32'hA5A5A5A5, 1'b1);
    issue(1'b0, 32'h21, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 1'b1);

    // Randomised mix, mostly aligned.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    // Async reset mid-read, after ReadData holds a non-zero value.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 32'h30, 32'h0, 1'b0);
    #2 Reset_signal_n = 1'b0;
    #1;
    check("midrst_rdata", bus.ReadData, 32'h0);
    check("midrst_ack",   {31'b0, bus.ack},  32'h0);
    check("midrst_busy",  {31'b0, bus.busy}, 32'h0);
    @(negedge Clk);
    Reset_signal_n = 1'b1;

    // Reset before the write commit edge: write must be lost.
    issue(1'b1, 32'h20, 32'h55AA55AA, 1'b0);
    Reset_signal_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_signal_n = 1'b1;
    repeat (3) @(negedge Clk);
    issue(1'b0, 32'h20, 32'h0, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (q.size() != 0) flag("drain_timeout");
    repeat (3) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
